// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM draw/clear sequencer: frame geometry,
// command opcodes, FSM state encoding and the linear pixel index type.
package vram_pkg;

    localparam int VRAM_W        = 128;
    localparam int VRAM_H        = 64;
    localparam int VRAM_PIX_BITS = 2;

    localparam int HPOS_W    = $clog2(VRAM_W);
    localparam int VPOS_W    = $clog2(VRAM_H);
    localparam int PIX_IDX_W = HPOS_W + VPOS_W;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_LATCH = 3'd3,
        ST_PRD   = 3'd4,
        ST_PWR   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Column-major linear index: {hpos, vpos}
    typedef logic [PIX_IDX_W-1:0] pix_idx_t;

    function automatic logic [HPOS_W-1:0] pix_hpos(input pix_idx_t idx);
        return idx[PIX_IDX_W-1:VPOS_W];
    endfunction

    function automatic logic [VPOS_W-1:0] pix_vpos(input pix_idx_t idx);
        return idx[VPOS_W-1:0];
    endfunction

endpackage

// File: rtl/vram_draw_ctrl.sv
// Command sequencer owning the VRAM write port: CLEAR zeroes the frame,
// DRAW XORs an 8-pixel-wide sprite fetched from RAM, reporting collisions.
module vram_draw_ctrl
    import vram_pkg::*;
#(
    parameter int VRAM_W = vram_pkg::VRAM_W,
    parameter int VRAM_H = vram_pkg::VRAM_H,
    localparam int HW    = $clog2(VRAM_W),
    localparam int VW    = $clog2(VRAM_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [HW-1:0]            cmd_x,
    input  logic [VW-1:0]            cmd_y,
    input  logic [3:0]               cmd_n,
    input  logic [11:0]              cmd_i,
    input  logic [VRAM_PIX_BITS-1:0] cmd_color,
    output logic                     busy,
    output logic                     done,
    output logic                     collision,
    output logic [11:0]              ram_addr,
    input  logic [7:0]               ram_dout,
    output logic [HW-1:0]            vram_hpos,
    output logic [VW-1:0]            vram_vpos,
    output logic [VRAM_PIX_BITS-1:0] vram_pixeli,
    input  logic [VRAM_PIX_BITS-1:0] vram_pixelo,
    output logic                     vram_we
);

    state_t                     state;
    logic [HW+VW-1:0]           clr_cnt;
    logic [3:0]                 row;
    logic [2:0]                 col;
    logic [7:0]                 shreg;
    logic [HW-1:0]              x_r;
    logic [VW-1:0]              y_r;
    logic [3:0]                 n_r;
    logic [11:0]                i_r;
    logic [VRAM_PIX_BITS-1:0]   color_r;
    logic                       coll_r;

    logic [HW-1:0]              draw_h;
    logic [VW-1:0]              draw_v;
    logic                       hit;

    // Coordinates wrap naturally through truncation to the port widths
    assign draw_h = x_r + HW'(col);
    assign draw_v = y_r + VW'(row);
    assign hit    = shreg[7] & (|(vram_pixelo & color_r));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            row     <= '0;
            col     <= '0;
            shreg   <= '0;
            x_r     <= '0;
            y_r     <= '0;
            n_r     <= '0;
            i_r     <= '0;
            color_r <= '0;
            coll_r  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x_r     <= cmd_x;
                        y_r     <= cmd_y;
                        n_r     <= cmd_n;
                        i_r     <= cmd_i;
                        color_r <= cmd_color;
                        coll_r  <= 1'b0;
                        clr_cnt <= '0;
                        row     <= '0;
                        if (cmd_op == OP_CLEAR)
                            state <= ST_CLEAR;
                        else if (cmd_n == 4'd0)
                            state <= ST_DONE;
                        else
                            state <= ST_FETCH;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1)
                        state <= ST_DONE;
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    shreg <= ram_dout;
                    col   <= '0;
                    state <= ST_PRD;
                end
                ST_PRD: state <= ST_PWR;
                ST_PWR: begin
                    if (hit)
                        coll_r <= 1'b1;
                    shreg <= {shreg[6:0], 1'b0};
                    col   <= col + 1'b1;
                    if (col != 3'd7)
                        state <= ST_PRD;
                    else if (row == n_r - 4'd1)
                        state <= ST_DONE;
                    else begin
                        row   <= row + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready   = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        collision   = coll_r;
        ram_addr    = '0;
        vram_hpos   = '0;
        vram_vpos   = '0;
        vram_pixeli = '0;
        vram_we     = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                vram_hpos = clr_cnt[HW+VW-1:VW];
                vram_vpos = clr_cnt[VW-1:0];
                vram_we   = 1'b1;
            end
            ST_FETCH: ram_addr = i_r + 12'(row);
            ST_PRD: begin
                vram_hpos = draw_h;
                vram_vpos = draw_v;
            end
            ST_PWR: begin
                vram_hpos   = draw_h;
                vram_vpos   = draw_v;
                vram_pixeli = vram_pixelo ^ color_r;
                vram_we     = shreg[7];
            end
            default: ;
        endcase
    end

endmodule
